// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
//   Definitions shared by the LRU cache and its miss-handling controller.
//   - ADDR_W / DATA_W : RAM address (block tag) and data widths
//   - CNT_W           : width of the saturating statistics counters
//   - mc_state_t      : miss controller sequencing states
//   - sat_inc()       : increment that holds at all-ones
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } mc_state_t;

    // Statistics must never wrap back to zero; they stick at the maximum.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cache_mem_controller.sv
// ----------------------------------------------------------------------------
// cache_mem_controller
//   Miss-handling sequencer between the 4-way fully-associative LRU cache and
//   the 32x8 backing RAM. On a miss it writes back a dirty victim (one cycle),
//   reads the requested byte, waits RAM_LATENCY cycles for it, and hands it to
//   the cache with a one-cycle fill_valid strobe. It owns the RAM port.
//
// Parameters
//   RAM_LATENCY   cycles from address presentation to valid qRAM (1..7)
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   miss_req, miss_addr     refill request (held until fill_valid) and tag
//   victim_dirty/tag/data   victim block to write back when dirty
//   qRAM                    RAM read data
//   ram_addr/wren/data      RAM port (registered)
//   busy                    a transaction is in progress
//   fill_valid/data/tag     one-cycle strobe with the fetched byte and tag
//   miss_count, wb_count    saturating completed-refill / write-back counts
// ----------------------------------------------------------------------------
module cache_mem_controller
    import cache_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_tag,
    input  logic [DATA_W-1:0] victim_data,
    input  logic [DATA_W-1:0] qRAM,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              fill_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] fill_tag,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  wb_count
);

    localparam logic [2:0] LAT_LAST = 3'(RAM_LATENCY - 1);

    mc_state_t         state_q,      state_d;
    logic [2:0]        lat_cnt_q,    lat_cnt_d;
    logic [ADDR_W-1:0] miss_addr_q,  miss_addr_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic [DATA_W-1:0] ram_data_q,   ram_data_d;
    logic [DATA_W-1:0] fill_data_q,  fill_data_d;
    logic [ADDR_W-1:0] fill_tag_q,   fill_tag_d;
    logic [CNT_W-1:0]  miss_count_q, miss_count_d;
    logic [CNT_W-1:0]  wb_count_q,   wb_count_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            miss_addr_q  <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            fill_data_q  <= '0;
            fill_tag_q   <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            miss_addr_q  <= miss_addr_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            fill_data_q  <= fill_data_d;
            fill_tag_q   <= fill_tag_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        miss_addr_d  = miss_addr_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        fill_data_d  = fill_data_q;
        fill_tag_d   = fill_tag_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;

        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    miss_addr_d = miss_addr;
                    lat_cnt_d   = '0;
                    // The victim tag/data go straight into the RAM port
                    // registers: the write-back is the very next cycle, so a
                    // separate victim latch would only duplicate them.
                    if (victim_dirty) begin
                        state_d    = WB;
                        ram_addr_d = victim_tag;
                        ram_data_d = victim_data;
                    end else begin
                        state_d    = RD;
                        ram_addr_d = miss_addr;
                    end
                end
            end

            WB: begin
                wb_count_d = sat_inc(wb_count_q);
                ram_addr_d = miss_addr_q;
                state_d    = RD;
            end

            RD: begin
                if (lat_cnt_q == LAT_LAST) begin
                    fill_data_d  = qRAM;
                    fill_tag_d   = miss_addr_q;
                    miss_count_d = sat_inc(miss_count_q);
                    state_d      = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end

            DONE: begin
                // miss_req is deliberately not looked at here; a still-high
                // request is picked up in the following IDLE cycle.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: strobes decode directly from the state register so reset
    // clears them asynchronously along with everything else.
    // ------------------------------------------------------------------
    assign busy       = (state_q != IDLE);
    assign ram_wren   = (state_q == WB);
    assign fill_valid = (state_q == DONE);
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign fill_data  = fill_data_q;
    assign fill_tag   = fill_tag_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_mem_controller.sv
// ----------------------------------------------------------------------------
// tb_cache_mem_controller
//   Bench for cache_mem_controller: one instance at RAM_LATENCY=2 with a
//   pipelined RAM model, and one at RAM_LATENCY=1 for back-to-back requests.
// ----------------------------------------------------------------------------
module tb_cache_mem_controller;

    localparam int unsigned LAT  = 2;
    localparam int unsigned LAT1 = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    // main instance (LAT)
    logic       miss_req = 1'b0;
    logic [4:0] miss_addr = '0;
    logic       victim_dirty = 1'b0;
    logic [4:0] victim_tag = '0;
    logic [7:0] victim_data = '0;
    logic [7:0] qRAM;
    logic [4:0] ram_addr;
    logic       ram_wren;
    logic [7:0] ram_data;
    logic       busy;
    logic       fill_valid;
    logic [7:0] fill_data;
    logic [4:0] fill_tag;
    logic [7:0] miss_count;
    logic [7:0] wb_count;

    // back-to-back instance (LAT1)
    logic       b_miss_req = 1'b0;
    logic [4:0] b_miss_addr = '0;
    logic [7:0] b_qRAM;
    logic [4:0] b_ram_addr;
    logic       b_ram_wren;
    logic [7:0] b_ram_data;
    logic       b_busy;
    logic       b_fill_valid;
    logic [7:0] b_fill_data;
    logic [4:0] b_fill_tag;
    logic [7:0] b_miss_count;
    logic [7:0] b_wb_count;

    always #5 clock = ~clock;

    cache_mem_controller #(.RAM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data),
        .qRAM(qRAM),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_data(ram_data),
        .busy(busy), .fill_valid(fill_valid), .fill_data(fill_data), .fill_tag(fill_tag),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    cache_mem_controller #(.RAM_LATENCY(LAT1)) dut_b2b (
        .clock(clock), .reset(reset),
        .miss_req(b_miss_req), .miss_addr(b_miss_addr),
        .victim_dirty(1'b0), .victim_tag(5'd0), .victim_data(8'd0),
        .qRAM(b_qRAM),
        .ram_addr(b_ram_addr), .ram_wren(b_ram_wren), .ram_data(b_ram_data),
        .busy(b_busy), .fill_valid(b_fill_valid), .fill_data(b_fill_data), .fill_tag(b_fill_tag),
        .miss_count(b_miss_count), .wb_count(b_wb_count)
    );

    // ------------------------------------------------------------------
    // RAM model: data for an address appears LAT cycles after it is driven.
    // ------------------------------------------------------------------
    localparam int unsigned PIPE_IDX = (LAT >= 2) ? LAT - 2 : 0;
    logic [7:0] ram [0:31];
    logic [4:0] addr_pipe [0:7];

    always @(posedge clock) begin
        if (ram_wren) ram[ram_addr] <= ram_data;
        addr_pipe[0] <= ram_addr;
        for (int i = 1; i < 8; i++) addr_pipe[i] <= addr_pipe[i-1];
    end

    assign qRAM = (LAT == 1) ? ram[ram_addr] : ram[addr_pipe[PIPE_IDX]];

    // Read-only content for the latency-1 instance, combinational lookup.
    function automatic logic [7:0] b_ram_val(input logic [4:0] a);
        return {3'b101, a} ^ 8'h5A;
    endfunction
    assign b_qRAM = b_ram_val(b_ram_addr);

    // ------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [4:0]  tag;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    logic        fv_prev = 1'b0;
    logic [7:0]  exp_mem [0:31];
    logic [7:0]  exp_miss = '0;
    logic [7:0]  exp_wb   = '0;

    function automatic logic [7:0] sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Every fill strobe is matched against the oldest outstanding request.
    always @(negedge clock) begin
        if (fill_valid) begin
            check_val("fill_single_pulse", fv_prev, 0);
            if (sb_q.size() == 0) begin
                check_val("fill_unexpected", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("fill_data", fill_data, mon_e.data);
                check_val("fill_tag", fill_tag, mon_e.tag);
                check_val("fill_cycle", cyc, mon_e.cyc);
            end
        end
        fv_prev = fill_valid;
    end

    // One miss transaction on the main instance; optionally checks the RAM
    // port every cycle and/or scrambles the request inputs while busy.
    task automatic do_miss(input logic [4:0] a, input logic d, input logic [4:0] vt,
                           input logic [7:0] vd, input bit verbose, input bit mutate);
        int unsigned t_req;
        bit          seen;
        exp_t        e;
        @(negedge clock);
        miss_req     = 1'b1;
        miss_addr    = a;
        victim_dirty = d;
        victim_tag   = vt;
        victim_data  = vd;
        t_req = cyc + 1;
        if (d) begin
            exp_mem[vt] = vd;
            exp_wb      = sat8(exp_wb);
        end
        exp_miss = sat8(exp_miss);
        e.tag  = a;
        e.data = exp_mem[a];
        e.cyc  = t_req + LAT + (d ? 1 : 0);
        sb_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (fill_valid) begin
                seen = 1'b1;
            end else begin
                if (verbose) begin
                    check_val("busy_in_txn", busy, 1);
                    if (d && k == 0) begin
                        check_val("wb_wren", ram_wren, 1);
                        check_val("wb_addr", ram_addr, vt);
                        check_val("wb_data", ram_data, vd);
                    end else begin
                        check_val("rd_wren", ram_wren, 0);
                        check_val("rd_addr", ram_addr, a);
                    end
                end
                if (mutate && k == 1) begin
                    miss_addr    = 5'd30;
                    victim_dirty = 1'b1;
                    victim_tag   = 5'd4;
                    victim_data  = 8'hFF;
                end
            end
        end
        if (!seen) check_val("fill_timeout", seen, 1);
        miss_req = 1'b0;
        @(negedge clock);
        check_val("idle_after_done", busy, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int unsigned b_fills [3];
    int unsigned nb;
    int unsigned b_t;

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i]     = 8'(i * 37 + 11);
            exp_mem[i] = 8'(i * 37 + 11);
        end
        ram[9]     = 8'h3C;
        exp_mem[9] = 8'h3C;

        // reset state
        repeat (2) @(negedge clock);
        check_val("rst_busy", busy, 0);
        check_val("rst_wren", ram_wren, 0);
        check_val("rst_fill_valid", fill_valid, 0);
        check_val("rst_ram_addr", ram_addr, 0);
        check_val("rst_miss_count", miss_count, 0);
        reset = 1'b0;

        // clean miss
        do_miss(5'd9, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
        check_val("clean_miss_count", miss_count, 1);
        check_val("clean_wb_count", wb_count, 0);

        // dirty miss
        do_miss(5'd3, 1'b1, 5'd21, 8'hA5, 1'b1, 1'b0);
        check_val("dirty_miss_count", miss_count, exp_miss);
        check_val("dirty_wb_count", wb_count, exp_wb);
        // read back the written-back byte
        do_miss(5'd21, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);

        // input changes while busy must be ignored
        do_miss(5'd12, 1'b1, 5'd7, 8'h11, 1'b1, 1'b1);
        check_val("mutate_wb_count", wb_count, exp_wb);
        do_miss(5'd4, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
        do_miss(5'd30, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
        check_val("mutate_miss_count", miss_count, exp_miss);

        // reset in the middle of a dirty transaction
        @(negedge clock);
        miss_req = 1'b1; miss_addr = 5'd10; victim_dirty = 1'b1;
        victim_tag = 5'd2; victim_data = 8'h77;
        exp_mem[2] = 8'h77;
        @(negedge clock);             // WB
        @(negedge clock);             // RD
        check_val("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_val("async_busy", busy, 0);
        check_val("async_wren", ram_wren, 0);
        check_val("async_ram_addr", ram_addr, 0);
        check_val("async_ram_data", ram_data, 0);
        check_val("async_fill_valid", fill_valid, 0);
        check_val("async_fill_data", fill_data, 0);
        check_val("async_fill_tag", fill_tag, 0);
        check_val("async_miss_count", miss_count, 0);
        check_val("async_wb_count", wb_count, 0);
        sb_q.delete();
        exp_miss = '0;
        exp_wb   = '0;
        // request held through a reset edge: reset wins
        @(negedge clock);
        check_val("rst_wins_busy", busy, 0);
        miss_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_val("post_rst_busy", busy, 0);
            check_val("post_rst_wren", ram_wren, 0);
        end
        do_miss(5'd2, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);

        // saturation
        for (int i = 0; i < 260; i++) begin
            do_miss(5'($urandom_range(0, 31)), 1'b1, 5'($urandom_range(0, 31)),
                    8'($urandom), 1'b0, 1'b0);
            if (i == 254) begin
                check_val("sat_pre_miss", miss_count, 8'd255);
                check_val("sat_pre_wb", wb_count, 8'd255);
            end
        end
        check_val("sat_miss_count", miss_count, 8'd255);
        check_val("sat_wb_count", wb_count, 8'd255);
        do_miss(5'd9, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
        check_val("sat_hold_miss", miss_count, 8'd255);

        // back-to-back on the latency-1 instance
        @(negedge clock);
        b_miss_req  = 1'b1;
        b_miss_addr = 5'd17;
        b_t = cyc + 1;
        nb  = 0;
        for (int k = 0; k < 40 && nb < 3; k++) begin
            @(negedge clock);
            if (b_fill_valid) begin
                b_fills[nb] = cyc;
                check_val("b2b_data", b_fill_data, b_ram_val(5'd17));
                check_val("b2b_tag", b_fill_tag, 5'd17);
                nb++;
            end
            check_val("b2b_wren", b_ram_wren, 0);
        end
        b_miss_req = 1'b0;
        check_val("b2b_fill_count", nb, 3);
        if (nb == 3) begin
            check_val("b2b_first", b_fills[0], b_t + LAT1);
            check_val("b2b_gap1", b_fills[1] - b_fills[0], LAT1 + 2);
            check_val("b2b_gap2", b_fills[2] - b_fills[1], LAT1 + 2);
        end
        @(negedge clock);
        check_val("b2b_idle", b_busy, 0);
        check_val("b2b_miss_count", b_miss_count, 3);
        check_val("b2b_wb_count", b_wb_count, 0);
        check_val("b2b_ram_data", b_ram_data, 0);

        check_val("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
